idex_hazard_stage: RTL
======================

Name: idex_hazard_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, combined with load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX. Its ex_rs and ex_rt outputs are the Rs/Rt inputs of the forwarding unit.
- On a load-use dependency it stalls PC and IF/ID and injects a bubble, because forwarding cannot cover that case.
- Also supports branch flush, a global hold, and a saturating stall-cycle counter.

Parameters:
- DATA_W, 32, width of operand and immediate datapath.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  global freeze (memory busy); ID/EX keeps its contents.
- flush  in  1  branch taken/jump in ID; the next ID/EX load becomes a bubble.
- id_rs, id_rt, id_rd  in  5 each  register specifiers from IF/ID decode.
- id_uses_rt  in  1  the ID instruction reads rt as a source (R-type, sw, beq).
- id_read_data1, id_read_data2  in  DATA_W each  register file outputs.
- id_imm  in  DATA_W  sign-extended immediate.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  in  1 each  decoded control.
- id_alu_op  in  2  ALU operation class.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID register enable (combinational).
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers.
- ex_read_data1, ex_read_data2, ex_imm  out  DATA_W each  registered.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst  out  1 each  registered control.
- ex_alu_op  out  2  registered control.
- stall_count  out  CNT_W  number of bubble cycles inserted since reset.

Behaviour:
- Reset (async, active-high):
  - All ex_* outputs go to 0 immediately, which is a bubble.
  - stall_count = 0.
  - pc_write and ifid_write follow the combinational equations below with the zeroed state.
- Load-use detection (combinational):
  - lu_stall = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
  - pc_write = ~hold & ~lu_stall.
  - ifid_write = ~hold & ~lu_stall.
- Register update on rising clk, priority highest first:
  1. hold=1: all ex_* and stall_count unchanged. Takes priority over flush and lu_stall.
  2. flush=1: control fields (reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op) cleared. Datapath and specifier fields load from id_*. stall_count unchanged.
  3. lu_stall=1: control fields cleared, datapath fields load from id_*, stall_count increments.
  4. Otherwise: all ex_* load from id_*.
- Bubbles:
  - A bubble always has ex_mem_read = 0, so a stall lasts exactly one cycle per load-use pair.
  - Because ex_rt is loaded into the bubble, the forwarding unit sees a harmless non-writing entry (ex_reg_write = 0).
- Latency: one cycle from id_* to ex_*.
- stall_count saturates at all-ones. It has no wrap.
- Register $0:
  - A load writing $0 never stalls.
  - id_rs = 0 matching ex_rt = 0 is excluded by the ex_rt != 0 term.
- Simultaneous flush and lu_stall:
  - flush wins and stall_count does not increment.
  - pc_write is still forced low by lu_stall for that cycle. The branch unit owns the PC mux override.
- Reset deasserted mid-stream: first clock after release loads normally. No residual stall state exists.

Decomposition:
- Shared package pipe_pkg:
  - ALU_OP_* encodings (ADD=00, SUB=01, FUNCT=10).
  - a packed control-bundle typedef ctrl_t of 8 bits: reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[1:0].
  - constant CTRL_BUBBLE = 0.
- One sub-module: load_use_detect, purely combinational. It computes lu_stall and drives pc_write and ifid_write. The register and counter stay in the top module.

Test Plan:
- Reset behaviour: assert reset mid-clock with ex_reg_write = 1 -> all ex_* = 0 immediately, stall_count = 0.
- Load-use stall: lw $5 in EX (ex_mem_read=1, ex_rt=5), ID add with rs=5 -> pc_write = 0, ifid_write = 0; next edge ex_reg_write = 0; the following cycle the add loads normally; stall_count = 1.
- No stall on $0 or an unread rt: lw $0 with rs=0 -> no stall. lw $7 with ID addi rt=7 and id_uses_rt=0 -> no stall.
- Hold priority: hold=1 with lu_stall=1 for 3 cycles -> ex_* frozen, stall_count unchanged, pc_write = 0; after release, one bubble and stall_count +1.
- Flush and stall together: flush=1 and lu_stall=1 -> controls cleared, stall_count unchanged. Flush alone with id_reg_write=1 -> ex_reg_write = 0, ex_read_data1 = id value.
- Counter saturation: CNT_W=4, 17 load-use pairs -> stall_count = 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline.
//   alu_op_e    : ALU operation class carried from ID to EX
//   ctrl_t      : packed 8-bit control bundle travelling with each instruction
//   CTRL_BUBBLE : control value of an inserted no-op (writes nothing, reads nothing)
package pipe_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   hold        : global freeze, also blocks PC / IF-ID updates
//   ex_mem_read : instruction in EX is a load
//   ex_rt       : load destination register
//   id_rs/id_rt : source specifiers of the instruction in ID
//   id_uses_rt  : ID instruction actually reads rt
//   lu_stall    : load result is needed by ID before it can be forwarded
//   pc_write    : PC update enable
//   ifid_write  : IF/ID register enable
module load_use_detect (
    input  logic       hold,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu_stall,
    output logic       pc_write,
    output logic       ifid_write
);

    // A load into $0 produces nothing to wait for.
    assign lu_stall = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign pc_write   = !hold && !lu_stall;
    assign ifid_write = !hold && !lu_stall;

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
//   clk, reset           : rising-edge clock, async active-high reset
//   hold                 : freeze all state
//   flush                : next load into ID/EX becomes a bubble (no count)
//   id_*                 : decoded operands, specifiers and control from ID
//   pc_write, ifid_write : combinational front-end enables
//   ex_*                 : registered operands, specifiers and control for EX
//   stall_count          : saturating count of load-use bubbles since reset
module idex_hazard_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [1:0]        id_alu_op,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [CNT_W-1:0]  stall_count
);

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_d, ctrl_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] d1_q, d2_q, imm_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              lu_stall;

    assign id_ctrl = '{reg_write:  id_reg_write,
                       mem_to_reg: id_mem_to_reg,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       alu_src:    id_alu_src,
                       reg_dst:    id_reg_dst,
                       alu_op:     id_alu_op};

    load_use_detect u_lud (
        .hold        (hold),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .lu_stall    (lu_stall),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write)
    );

    // Flush takes precedence over a simultaneous load-use stall: the bubble
    // is still inserted but it is accounted to the branch, not the counter.
    always_comb begin
        ctrl_d = id_ctrl;
        cnt_d  = cnt_q;
        if (flush || lu_stall) begin
            ctrl_d = CTRL_BUBBLE;
        end
        if (lu_stall && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_BUBBLE;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            imm_q  <= '0;
            cnt_q  <= '0;
        end else if (!hold) begin
            ctrl_q <= ctrl_d;
            rs_q   <= id_rs;
            rt_q   <= id_rt;
            rd_q   <= id_rd;
            d1_q   <= id_read_data1;
            d2_q   <= id_read_data2;
            imm_q  <= id_imm;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;
    assign ex_read_data1 = d1_q;
    assign ex_read_data2 = d2_q;
    assign ex_imm        = imm_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign stall_count   = cnt_q;

endmodule
